// File: rtl/pipelined_adder_tree.sv
// rtl/pipelined_adder_tree.sv - pipelined N-operand adder tree with optional packet accumulator

module pipelined_adder_tree #(
    parameter int W      = 8,
    parameter int N      = 4,
    parameter int ACC_EN = 0,
    parameter int ACC_W  = 16,
    localparam int LV    = $clog2(N),
    localparam int OW    = (ACC_EN != 0) ? ACC_W : W + LV
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*W-1:0]  in_data,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OW-1:0]   out_sum,
    output logic            out_ovf
);

    localparam int SW = W + LV;

    // Bit offset of tree level k inside the flat level bus; level k holds
    // N>>k sums, each W+k bits wide, packed in ascending operand order.
    function automatic int lvl_off(input int k);
        int o;
        o = 0;
        for (int j = 0; j < k; j++) begin
            o += (N >> j) * (W + j);
        end
        return o;
    endfunction

    localparam int TOT = lvl_off(LV + 1);

    // Level 0 is the raw input beat; levels 1..LV are the registered sums.
    logic [TOT-1:0] tree_bus;
    logic [LV:1]    vld_q;
    logic [SW-1:0]  tree_sum;
    logic           tree_vld;
    logic           adv;

    // One global advance: the whole pipeline moves only when the output slot
    // is empty or being drained this cycle, so bubbles travel with the data.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign tree_bus[N*W-1:0] = in_data;

    genvar k;
    generate
        for (k = 1; k <= LV; k++) begin : g_lvl
            localparam int CNT     = N >> k;
            localparam int IW      = W + k - 1;
            localparam int LW      = W + k;
            localparam int OFF_IN  = lvl_off(k - 1);
            localparam int OFF_OUT = lvl_off(k);

            logic [CNT*LW-1:0] sum_d;
            logic [CNT*LW-1:0] sum_q;

            // Pairwise sums of the previous level, widened by one bit so no carry is lost.
            always_comb begin
                sum_d = '0;
                for (int i = 0; i < CNT; i++) begin
                    sum_d[i*LW +: LW] = LW'(tree_bus[OFF_IN + (2*i)*IW +: IW])
                                      + LW'(tree_bus[OFF_IN + (2*i+1)*IW +: IW]);
                end
            end

            // Level register; holds while the output is stalled.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_q <= '0;
                end else if (adv) begin
                    sum_q <= sum_d;
                end
            end

            assign tree_bus[OFF_OUT +: CNT*LW] = sum_q;
        end
    endgenerate

    // Valid bits march one level per advancing cycle alongside the sums.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (adv) begin
            vld_q[1] <= in_valid;
            for (int s = 2; s <= LV; s++) begin
                vld_q[s] <= vld_q[s-1];
            end
        end
    end

    assign tree_sum = tree_bus[lvl_off(LV) +: SW];
    assign tree_vld = vld_q[LV];

    generate
        if (ACC_EN != 0) begin : g_acc
            logic [LV:1]      last_q;
            logic [ACC_W-1:0] acc_q;
            logic             ovf_q;
            logic             first_q;
            logic             ovld_q;
            logic [ACC_W:0]   acc_sum;

            // The packet-end flag rides the tree next to its beat.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    last_q <= '0;
                end else if (adv) begin
                    last_q[1] <= in_last;
                    for (int s = 2; s <= LV; s++) begin
                        last_q[s] <= last_q[s-1];
                    end
                end
            end

            // One spare bit catches the carry that signals saturation.
            always_comb begin
                acc_sum = (first_q ? '0 : {1'b0, acc_q}) + (ACC_W+1)'(tree_sum);
            end

            // Saturating accumulator; a result is presented only at packet end.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_q   <= '0;
                    ovf_q   <= 1'b0;
                    first_q <= 1'b1;
                    ovld_q  <= 1'b0;
                end else if (adv) begin
                    ovld_q <= tree_vld && last_q[LV];
                    if (tree_vld) begin
                        acc_q   <= acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
                        ovf_q   <= (first_q ? 1'b0 : ovf_q) | acc_sum[ACC_W];
                        first_q <= last_q[LV];
                    end
                end
            end

            assign out_valid = ovld_q;
            assign out_sum   = acc_q;
            assign out_ovf   = ovf_q;
        end else begin : g_sum
            logic unused_last;

            assign unused_last = in_last;
            assign out_valid   = tree_vld;
            assign out_sum     = tree_sum;
            assign out_ovf     = 1'b0;
        end
    endgenerate

endmodule
